// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, constants and state type for the CORDIC sequencer
package cordic_pkg;

  localparam int DATA_W  = 16;
  localparam int INT_W   = 18;
  localparam int ANGLE_W = 18;
  localparam int ITER_W  = 5;

  localparam logic [ANGLE_W-1:0] HALF_PI = 18'h10000;

  // K in Q1.15; the datapath never removes it, so consumers scale if needed
  localparam logic [15:0] CORDIC_GAIN_Q15 = 16'hD2C6;

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} cordic_state_t;

endpackage

// File: rtl/cordic_ctrl_gamma_mem.sv
// rtl/cordic_ctrl_gamma_mem.sv - arctan(2^-i) table, angle units of 2^18 per full turn
module gamma_mem
  import cordic_pkg::*;
(
  input  logic [ITER_W-1:0] iter,
  output logic [15:0]       gamma
);

  always_comb begin
    gamma = '0;
    case (iter)
      5'd0:  gamma = 16'd32768;
      5'd1:  gamma = 16'd19344;
      5'd2:  gamma = 16'd10221;
      5'd3:  gamma = 16'd5188;
      5'd4:  gamma = 16'd2604;
      5'd5:  gamma = 16'd1303;
      5'd6:  gamma = 16'd652;
      5'd7:  gamma = 16'd326;
      5'd8:  gamma = 16'd163;
      5'd9:  gamma = 16'd81;
      5'd10: gamma = 16'd41;
      5'd11: gamma = 16'd20;
      5'd12: gamma = 16'd10;
      5'd13: gamma = 16'd5;
      5'd14: gamma = 16'd3;
      5'd15: gamma = 16'd1;
      default: gamma = '0;
    endcase
  end

endmodule

// File: rtl/cordic_ctrl.sv
// rtl/cordic_ctrl.sv - iterative rotation-mode CORDIC with quadrant pre-rotation
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_x,
  input  logic [DATA_W-1:0]  in_y,
  input  logic [ANGLE_W-1:0] in_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INT_W-1:0]   out_x,
  output logic [INT_W-1:0]   out_y,
  output logic [ANGLE_W-1:0] out_z,
  output logic               busy
);

  cordic_state_t state, state_nxt;

  logic signed [INT_W-1:0]   x, y;
  logic signed [ANGLE_W-1:0] z;
  logic [ITER_W-1:0]         iter;
  logic [15:0]               gamma;
  logic signed [ANGLE_W-1:0] gamma_ext;
  logic signed [INT_W-1:0]   x_sh, y_sh;
  logic                      last_iter;

  gamma_mem u_gamma (
    .iter  (iter),
    .gamma (gamma)
  );

  assign gamma_ext = {{(ANGLE_W-16){1'b0}}, gamma};
  assign x_sh      = x >>> iter;
  assign y_sh      = y >>> iter;
  assign last_iter = (iter == ITER_W'(ITERS-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = PRE;
      PRE:                    state_nxt = ITER;
      ITER:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      iter <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x <= {{(INT_W-DATA_W){in_x[DATA_W-1]}}, in_x};
          y <= {{(INT_W-DATA_W){in_y[DATA_W-1]}}, in_y};
          z <= in_z;
        end
        PRE: begin
          // fold |z| > pi/2 into the CORDIC convergence range by a 90-degree swap
          case (z[ANGLE_W-1 -: 2])
            2'b01: begin
              x <= -y;
              y <= x;
              z <= z - HALF_PI;
            end
            2'b10: begin
              x <= y;
              y <= -x;
              z <= z + HALF_PI;
            end
            default: ;
          endcase
          iter <= '0;
        end
        ITER: begin
          if (!z[ANGLE_W-1]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - gamma_ext;
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + gamma_ext;
          end
          iter <= iter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_x = x;
  assign out_y = y;
  assign out_z = z;

endmodule

// File: tb/tb_cordic_ctrl.sv
// tb/tb_cordic_ctrl.sv - self-checking bench for cordic_ctrl against a real-valued rotation model
module tb_cordic_ctrl;
  import cordic_pkg::*;

  localparam int ITERS = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_x, in_y;
  logic [17:0]        in_z;
  logic               out_valid;
  logic               out_ready;
  logic [17:0]        out_x, out_y, out_z;
  logic               busy;

  cordic_ctrl #(.ITERS(ITERS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    vectors++;
    if (act - exp > tol || exp - act > tol) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic int s18(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // ideal rotation by z (2^18 units per turn), scaled by the finite-iteration gain
  task automatic model(input int x, input int y, input int z, output int ex, output int ey);
    real k, p, th;
    k = 1.0;
    p = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    th = real'(z) * 2.0 * 3.141592653589793 / 262144.0;
    ex = int'(k * (real'(x) * $cos(th) - real'(y) * $sin(th)));
    ey = int'(k * (real'(x) * $sin(th) + real'(y) * $cos(th)));
  endtask

  typedef struct {
    int x;
    int y;
    int acc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   mx, my;
  logic prev_ov = 1'b0;
  int   px, py, pz;
  bit   b2b = 1'b0;
  int   b2b_n = 0;
  int   last_acc = 0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        model(s16(in_x), s16(in_y), s18(in_z), mx, my);
        e.x   = mx;
        e.y   = my;
        e.acc = cyc;
        q.push_back(e);
        if (b2b) begin
          if (b2b_n > 0) chk("accept_spacing", cyc - last_acc, ITERS + 3, 0);
          b2b_n++;
        end
        last_acc = cyc;
      end
      if (out_valid) begin
        chk("in_ready_in_done", int'(in_ready), 0, 0);
        if (!prev_ov) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0, 0);
          end else begin
            chk("latency", cyc - q[0].acc, ITERS + 2, 0);
            chk("model_x", s18(out_x), q[0].x, 4);
            chk("model_y", s18(out_y), q[0].y, 4);
            chk("model_z", s18(out_z), 0, 3);
          end
        end else begin
          chk("hold_x", s18(out_x), px, 0);
          chk("hold_y", s18(out_y), py, 0);
          chk("hold_z", s18(out_z), pz, 0);
        end
        px = s18(out_x);
        py = s18(out_y);
        pz = s18(out_z);
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [17:0] z);
    int n;
    n = 0;
    in_x = x;
    in_y = y;
    in_z = z;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_timeout", 0, 1, 0);
  endtask

  task automatic run_vec(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic [17:0] z, input int ex, input int ey);
    send(x, y, z);
    wait_out();
    chk({nm, "_x"}, s18(out_x), ex, 4);
    chk({nm, "_y"}, s18(out_y), ey, 4);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] bx[4] = '{16'h2000, 16'hD000, 16'h3000, 16'hC000};
  logic [15:0] by[4] = '{16'h1000, 16'h2800, 16'hE000, 16'h0000};
  logic [17:0] bz[4] = '{18'h05555, 18'h2E38E, 18'h12345, 18'h3ABCD};

  initial begin
    int ex, ey, n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_z      = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_in_ready",  int'(in_ready),  1, 0);
    chk("rst_busy",      int'(busy),      0, 0);
    chk("rst_out_x",     s18(out_x),      0, 0);
    chk("rst_out_y",     s18(out_y),      0, 0);
    chk("rst_out_z",     s18(out_z),      0, 0);
    reset = 1'b0;

    model(16384, 0, 0, ex, ey);
    chk("model_pin_0_x", ex, 26981, 1);
    model(16384, 0, 32768, ex, ey);
    chk("model_pin_pi4_y", ey, 19079, 1);
    model(16384, 0, -131072, ex, ey);
    chk("model_pin_negpi_x", ex, -26981, 1);

    @(posedge clk);
    #1;
    send(16'h4000, 16'h0000, 18'h00000);
    wait_out();
    chk("zero_x", s18(out_x), 26981, 4);
    chk("zero_y", s18(out_y), 0, 4);
    chk("zero_z", s18(out_z), 0, 2);
    @(posedge clk);
    #1;

    run_vec("pi4",    16'h4000, 16'h0000, 18'h08000,  19079,  19079);
    run_vec("pi34",   16'h4000, 16'h0000, 18'h18000, -19079,  19079);
    run_vec("negpi",  16'h4000, 16'h0000, 18'h20000, -26981,      0);

    // backpressure with in_valid pulsed while busy
    out_ready = 1'b0;
    send(16'h4000, 16'h0000, 18'h08000);
    repeat (3) @(posedge clk);
    #1;
    in_x = 16'h1234;
    in_y = 16'h0555;
    in_z = 18'h01111;
    in_valid = 1'b1;
    @(negedge clk);
    chk("busy_in_ready", int'(in_ready), 0, 0);
    chk("busy_flag",     int'(busy),     1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(out_valid), 1, 0);
      chk("bp_in_ready",  int'(in_ready),  0, 0);
      @(negedge clk);
    end
    chk("bp_x", s18(out_x), 19079, 4);
    chk("bp_y", s18(out_y), 19079, 4);
    out_ready = 1'b1;
    send(16'h4000, 16'h0000, 18'h00000);
    wait_out();
    chk("after_bp_x", s18(out_x), 26981, 4);
    @(posedge clk);
    #1;

    // abort mid-iteration: iter reaches 7 after the eighth edge past the accept
    send(16'h4000, 16'h0000, 18'h08000);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", int'(out_valid), 0, 0);
    chk("abort_in_ready",  int'(in_ready),  1, 0);
    chk("abort_busy",      int'(busy),      0, 0);
    chk("abort_out_x",     s18(out_x),      0, 0);
    chk("abort_out_y",     s18(out_y),      0, 0);
    chk("abort_out_z",     s18(out_z),      0, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_vec("post_abort", 16'h4000, 16'h0000, 18'h00000, 26981, 0);

    // back-to-back with both handshakes held open
    b2b = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x = bx[i];
      in_y = by[i];
      in_z = bz[i];
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk("b2b_accept_timeout", 0, 1, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_out();
    @(posedge clk);
    #1;
    b2b = 1'b0;
    chk("b2b_accepts", b2b_n, 4, 0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
